// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-code converter arbiter: mode and FSM encodings
// plus the index-width helper.
package gray_conv_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Binary to reflected Gray code: G = B ^ (B >> 1).
module bin_to_gray #(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo NREQ. Output is a one-hot grant plus its encoded index.
module rr_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    // Scan NREQ candidates starting at ptr; the wrap subtracts NREQ so
    // unused index codes are never produced for non-power-of-two NREQ.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            cand = sum[IW-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gray_to_bin.sv
// Reflected Gray code to binary: each binary bit is the XOR of all Gray bits
// at and above its position.
module gray_to_bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shared bin<->Gray converter pair serving NREQ requesters through a
// round-robin arbiter into a single-entry registered response buffer.
// Optional: GRAY_CONV_ARBITER_RTCHK_EN adds o_rsp_err, a round-trip check of
// each result through the opposite converter.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ-1:0]   i_req_mode,
    input  logic [NREQ*N-1:0] i_req_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [N-1:0]      o_rsp_data,
    output logic [IW-1:0]     o_rsp_id,
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
    output logic              o_rsp_err,
`endif
    output logic              o_rsp_mode
);

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, gnt_idx;
    logic          acc, any_gnt, sel_mode;
    logic [N-1:0]  sel_data, b2g_out, g2b_out, conv;

    // Buffer can take a new word when empty or when the held one leaves now.
    assign acc = (state == ST_EMPTY) | (i_rsp_ready & o_rsp_valid);

    // Reset gates the enable so nothing is accepted during the reset cycle.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .en    (acc & ~i_rst),
        .grant (o_req_ready),
        .idx   (gnt_idx)
    );

    assign any_gnt  = |o_req_ready;
    assign sel_data = i_req_data[gnt_idx*N +: N];
    assign sel_mode = i_req_mode[gnt_idx];
    assign ptr_nxt  = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    bin_to_gray #(.N(N)) u_b2g (.bin(sel_data), .gray(b2g_out));
    gray_to_bin #(.N(N)) u_g2b (.gray(sel_data), .bin(g2b_out));

    assign conv = (sel_mode == MODE_G2B) ? g2b_out : b2g_out;

`ifdef GRAY_CONV_ARBITER_RTCHK_EN
    logic [N-1:0] rt_b2g, rt_g2b;
    logic         err_nxt;

    bin_to_gray #(.N(N)) u_rt_b2g (.bin(g2b_out), .gray(rt_b2g));
    gray_to_bin #(.N(N)) u_rt_g2b (.gray(b2g_out), .bin(rt_g2b));

    assign err_nxt = (sel_mode == MODE_G2B) ? (rt_b2g != sel_data) : (rt_g2b != sel_data);

    // Round-trip flag travels with the response word.
    always_ff @(posedge i_clk) begin
        if (i_rst)        o_rsp_err <= 1'b0;
        else if (any_gnt) o_rsp_err <= err_nxt;
    end
`endif

    // Buffer occupancy: fill on grant, drain when consumed with nothing new.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (any_gnt) state_nxt = ST_FULL;
            ST_FULL:  if (i_rsp_ready && !any_gnt) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    // Response payload and RR pointer update only on a grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_data <= '0;
            o_rsp_id   <= '0;
            o_rsp_mode <= MODE_B2G;
            ptr        <= '0;
        end else if (any_gnt) begin
            o_rsp_data <= conv;
            o_rsp_id   <= gnt_idx;
            o_rsp_mode <= sel_mode;
            ptr        <= ptr_nxt;
        end
    end

    assign o_rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (N=8, NREQ=4) with a transaction
// level reference model of arbitration order and conversions.
module tb_gray_conv_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, req_mode;
    logic [31:0]  req_data;
    logic         rsp_valid, rsp_ready, rsp_mode;
    logic [7:0]   rsp_data;
    logic [1:0]   rsp_id;
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
    logic         rsp_err;
`endif

    int checks = 0, failures = 0;

    // Reference model state.
    int          m_ptr = 0, m_id = 0, last_g = -1;
    bit          m_valid = 0, m_mode = 0;
    logic [7:0]  m_data = 8'h00;

    gray_conv_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_mode  (req_mode),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
        .o_rsp_err   (rsp_err),
`endif
        .o_rsp_mode  (rsp_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] b2g_ref(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR of all right shifts.
    function automatic logic [7:0] g2b_ref(input logic [7:0] g);
        logic [7:0] b = 8'h00;
        for (int s = 0; s < 8; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic int ref_grant(input logic [3:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic int model_grant();
        if (rst || !(!m_valid || rsp_ready)) return -1;
        return ref_grant(req_valid, m_ptr);
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r = 4'b0;
        int g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock and the model alongside it (no checking here).
    task automatic tick();
        int g = model_grant();
        logic [7:0] d = req_data[g < 0 ? 0 : g*8 +: 8];
        last_g = g;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_id = 0; m_mode = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_mode  = req_mode[g];
            m_data  = m_mode ? g2b_ref(d) : b2g_ref(d);
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_valid = 1;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 4'hF; req_mode = 4'h0; req_data = 32'h12345678; rsp_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        tick(); tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h id=%0d m=%b exp all zero", rsp_valid, rsp_data, rsp_id, rsp_mode);
        end
        rst = 0; req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_mode = 4'b0000; req_data = 32'h0000_0005; rsp_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant0 got=%b exp=0001", req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 8'h07, 2'd0, 1'b0}) begin
            failures++; $display("FAIL single_b2g got v=%b d=%h id=%0d exp v=1 d=07 id=0", rsp_valid, rsp_data, rsp_id);
        end
        req_mode = 4'b0001; req_data = 32'h0000_0080;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant1 got=%b exp=0001", req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 8'hFF, 2'd0, 1'b1}) begin
            failures++; $display("FAIL single_g2b got v=%b d=%h m=%b exp v=1 d=ff m=1", rsp_valid, rsp_data, rsp_mode);
        end
        req_valid = 4'h0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain got v=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        rst = 1; tick(); rst = 0;
        req_valid = 4'hF; req_mode = 4'($urandom); req_data = $urandom; rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (i % 4))) begin
                failures++; $display("FAIL rr_order cycle %0d got=%b exp=%b", i, req_ready, 4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, m_data, 2'(i % 4), m_mode}) begin
                failures++;
                $display("FAIL rr_rsp cycle %0d got v=%b d=%h id=%0d exp v=1 d=%h id=%0d", i, rsp_valid, rsp_data, rsp_id, m_data, i % 4);
            end
            req_data[last_g*8 +: 8] = 8'($urandom);
            req_mode[last_g] = 1'($urandom);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [10:0] snap;
        req_valid = 4'hF; rsp_ready = 1;
        #1;
        tick();
        snap = {m_data, 2'(m_id), m_mode};
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0) begin
                failures++; $display("FAIL bp_ready cycle %0d got=%b exp=0000", i, req_ready);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, snap}) begin
                failures++; $display("FAIL bp_hold cycle %0d got d=%h id=%0d exp d=%h id=%0d", i, rsp_data, rsp_id, snap[10:3], snap[2:1]);
            end
        end
        rsp_ready = 1;
        #1;
        checks++;
        if (req_ready !== exp_ready() || req_ready === 4'b0) begin
            failures++; $display("FAIL bp_release got=%b exp=%b", req_ready, exp_ready());
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {m_valid, m_data, 2'(m_id), m_mode}) begin
            failures++; $display("FAIL bp_next got d=%h id=%0d exp d=%h id=%0d", rsp_data, rsp_id, m_data, m_id);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_sparse();
        rst = 1; tick(); rst = 0;
        rsp_ready = 1; req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL sparse_setup got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL sparse_first got=%b exp=1000", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd3 || rsp_data !== m_data) begin
            failures++; $display("FAIL sparse_rsp3 got id=%0d d=%h exp id=3 d=%h", rsp_id, rsp_data, m_data);
        end
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL sparse_second got=%b exp=0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd1 || rsp_data !== m_data) begin
            failures++; $display("FAIL sparse_rsp1 got id=%0d d=%h exp id=1 d=%h", rsp_id, rsp_data, m_data);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'hF; rsp_ready = 0;
        #1;
        tick();
        rst = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0) begin
            failures++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== 12'h000) begin
            failures++; $display("FAIL rstmid_flush got v=%b d=%h id=%0d exp all zero", rsp_valid, rsp_data, rsp_id);
        end
        rst = 0; req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL rstmid_first got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = 4'h0; rsp_ready = 1;
        tick();
    endtask

    task automatic test_exhaustive();
        logic [7:0] g;
        rsp_ready = 1;
        for (int v = 0; v < 256; v++) begin
            req_valid = 4'b0100; req_mode[2] = 1'b0; req_data[23:16] = 8'(v);
            #1;
            tick();
            g = b2g_ref(8'(v));
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, g, 2'd2, 1'b0}) begin
                failures++; $display("FAIL exh_b2g v=%h got d=%h id=%0d exp d=%h id=2", v, rsp_data, rsp_id, g);
            end
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
            checks++;
            if (rsp_err !== 1'b0) begin
                failures++; $display("FAIL exh_err_b2g v=%h got err=%b exp 0", v, rsp_err);
            end
`endif
            req_mode[2] = 1'b1; req_data[23:16] = g;
            #1;
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_mode} !== {1'b1, 8'(v), 1'b1}) begin
                failures++; $display("FAIL exh_roundtrip v=%h got d=%h exp d=%h", v, rsp_data, 8'(v));
            end
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
            checks++;
            if (rsp_err !== 1'b0) begin
                failures++; $display("FAIL exh_err_g2b v=%h got err=%b exp 0", v, rsp_err);
            end
`endif
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(1) == 1) begin
                    req_valid[k] = 1'b1;
                    req_mode[k] = 1'($urandom);
                    req_data[k*8 +: 8] = 8'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++; $display("FAIL rand_grant cycle %0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {m_valid, m_data, 2'(m_id), m_mode}) begin
                failures++;
                $display("FAIL rand_rsp cycle %0d got v=%b d=%h id=%0d m=%b exp v=%b d=%h id=%0d m=%b",
                         c, rsp_valid, rsp_data, rsp_id, rsp_mode, m_valid, m_data, m_id, m_mode);
            end
`ifdef GRAY_CONV_ARBITER_RTCHK_EN
            checks++;
            if (rsp_valid && rsp_err !== 1'b0) begin
                failures++; $display("FAIL rand_err cycle %0d got err=%b exp 0", c, rsp_err);
            end
`endif
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        req_valid = 4'h0; rsp_ready = 1;
        tick();
    endtask

    initial begin
        rst = 1; req_valid = 4'h0; req_mode = 4'h0; req_data = 32'h0; rsp_ready = 1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_exhaustive();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
